// File: rtl/pipe_pkg.sv
// Shared types for elastic pipeline stages: occupancy states and ID/EXE control layout.
// The NOP control word is built from the field layout so it tracks any re-packing.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  localparam int CTRL_W_IDEX    = 10;
  localparam int EXE_CMD_LSB    = 0;
  localparam int EXE_CMD_W      = 4;
  localparam int BR_LSB         = 4;
  localparam int BR_W           = 3;
  localparam int MEM_WRITE_BIT  = 7;
  localparam int MEM_READ_BIT   = 8;
  localparam int WB_EN_BIT      = 9;

  function automatic logic [CTRL_W_IDEX-1:0] ctrl_pack(
    input logic                 wb_en,
    input logic                 mem_read,
    input logic                 mem_write,
    input logic [BR_W-1:0]      br,
    input logic [EXE_CMD_W-1:0] exe_cmd
  );
    logic [CTRL_W_IDEX-1:0] c;
    c                              = '0;
    c[WB_EN_BIT]                   = wb_en;
    c[MEM_READ_BIT]                = mem_read;
    c[MEM_WRITE_BIT]               = mem_write;
    c[BR_LSB +: BR_W]              = br;
    c[EXE_CMD_LSB +: EXE_CMD_W]    = exe_cmd;
    return c;
  endfunction

  // No write-back, no memory access, no branch: safe to inject as a bubble.
  localparam logic [CTRL_W_IDEX-1:0] CTRL_NOP =
    ctrl_pack(1'b0, 1'b0, 1'b0, {BR_W{1'b0}}, {EXE_CMD_W{1'b0}});

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the elastic stage: load-enabled register with synchronous clear.
// Latency: 1 cycle from ld to q. Backpressure: none, the owner decides when to load.
// Clear wins over load; reset returns the slot to zero.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register with 2-entry skid buffer, flush/bubble insertion and stall counter.
// Latency: 1 cycle accept-to-out_valid when empty; 1 entry/cycle sustained.
// Backpressure: in_ready decodes registered state only (low when both slots are full).
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = 10,
  parameter int                DATA_W      = 133,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_NOP),
  parameter bit                CLEAR_DATA  = 1'b0,
  parameter int                STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   stall_clr
);

  localparam int                     SLOT_W    = CTRL_W + DATA_W;
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  occ_state_e             state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic              accept, emit;
  logic              head_ld, head_clr, head_from_skid;
  logic              skid_ld, skid_clr;
  logic [SLOT_W-1:0] head_q, skid_q, head_in;

  assign in_ready  = (state_q != OCC_TWO);
  assign out_valid = (state_q != OCC_EMPTY);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    head_ld        = 1'b0;
    head_clr       = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      // Same-cycle input is dropped; an emit this cycle has already been seen downstream.
      state_d  = OCC_EMPTY;
      head_clr = CLEAR_DATA;
      skid_clr = CLEAR_DATA;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            head_ld = 1'b1;
            state_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && emit) begin
            head_ld = 1'b1;
          end else if (accept) begin
            skid_ld = 1'b1;
            state_d = OCC_TWO;
          end else if (emit) begin
            head_clr = CLEAR_DATA;
            state_d  = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (emit) begin
            head_ld        = 1'b1;
            head_from_skid = 1'b1;
            state_d        = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  assign head_in = head_from_skid ? skid_q : {in_ctrl, in_data};

  pipe_slot #(.W(SLOT_W)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (head_clr),
    .ld  (head_ld),
    .d   (head_in),
    .q   (head_q)
  );

  pipe_slot #(.W(SLOT_W)) u_skid (
    .clk (clk),
    .rst (rst),
    .clr (skid_clr),
    .ld  (skid_ld),
    .d   ({in_ctrl, in_data}),
    .q   (skid_q)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OCC_EMPTY;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_ctrl  = out_valid ? head_q[SLOT_W-1 -: CTRL_W] : CTRL_BUBBLE;
  assign out_data  = head_q[DATA_W-1:0];
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed vector table, streaming/saturation sequences,
// then random traffic against a queue-based reference model.
module tb_pipe_stage_elastic;
  localparam int CTRL_W = 10;
  localparam int DATA_W = 133;
  localparam int SCW    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, stall_clr = 1'b0;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] in_ctrl = '0, out_ctrl;
  logic [DATA_W-1:0] in_data = '0, out_data;
  logic [1:0]        occupancy;
  logic [SCW-1:0]    stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_elastic #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE('0), .CLEAR_DATA(1'b0), .STALL_CNT_W(SCW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of held entries plus a saturating stall count.
  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t mq[$];
  int   m_stall = 0;

  task automatic step();
    int   sz;
    bit   ov, ir, acc, em;
    ent_t e;
    sz  = mq.size();
    ov  = (sz > 0);
    ir  = (sz < 2);
    acc = in_valid && ir;
    em  = ov && out_ready;
    e.c = in_ctrl;
    e.d = in_data;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (stall_clr) m_stall = 0;
      else if (ov && !out_ready && m_stall < (2**SCW - 1)) m_stall++;
      if (flush) mq.delete();
      else begin
        if (em) void'(mq.pop_front());
        if (acc) mq.push_back(e);
      end
    end
    chk("m_out_valid", out_valid, mq.size() > 0);
    chk("m_in_ready", in_ready, mq.size() < 2);
    chk("m_occupancy", occupancy, mq.size());
    chk("m_stall_cnt", stall_cnt, m_stall);
    if (mq.size() > 0) begin
      chk("m_out_ctrl", out_ctrl, mq[0].c);
      chk("m_out_data", out_data, mq[0].d);
    end else begin
      chk("m_bubble_ctrl", out_ctrl, 0);
    end
  endtask

  typedef struct {
    logic        rst, flush, iv, ordy, sclr;
    logic [9:0]  ctrl;
    logic [15:0] data;
    logic        e_ov, e_ir;
    logic [1:0]  e_occ;
    logic [9:0]  e_ctrl;
    logic [15:0] e_data;
    logic [3:0]  e_stall;
  } vec_t;

  function automatic vec_t mk(input logic r, f, iv, o, s, input logic [9:0] c, input logic [15:0] d,
                              input logic eov, eir, input logic [1:0] eocc, input logic [9:0] ec,
                              input logic [15:0] ed, input logic [3:0] es);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ordy = o; v.sclr = s; v.ctrl = c; v.data = d;
    v.e_ov = eov; v.e_ir = eir; v.e_occ = eocc; v.e_ctrl = ec; v.e_data = ed; v.e_stall = es;
    return v;
  endfunction

  vec_t tbl[19];
  logic [DATA_W-1:0] sent[8];

  initial begin
    //             rst f iv or sc ctrl    data      ov ir occ ectrl   edata    stall
    tbl[0]  = mk(1, 0, 0, 0, 0, 10'h000, 16'h0000, 0, 1, 0, 10'h000, 16'h0000, 0);
    tbl[1]  = mk(0, 0, 1, 1, 0, 10'h155, 16'h00A5, 1, 1, 1, 10'h155, 16'h00A5, 0);
    tbl[2]  = mk(0, 0, 0, 1, 0, 10'h000, 16'h0000, 0, 1, 0, 10'h000, 16'h00A5, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0, 10'h0A1, 16'h0111, 1, 1, 1, 10'h0A1, 16'h0111, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0, 10'h0B2, 16'h0222, 1, 0, 2, 10'h0A1, 16'h0111, 1);
    tbl[5]  = mk(0, 0, 1, 1, 0, 10'h0C3, 16'h0333, 1, 1, 1, 10'h0B2, 16'h0222, 1);
    tbl[6]  = mk(0, 0, 0, 1, 0, 10'h000, 16'h0000, 0, 1, 0, 10'h000, 16'h0222, 1);
    tbl[7]  = mk(0, 0, 1, 0, 0, 10'h0D4, 16'h0444, 1, 1, 1, 10'h0D4, 16'h0444, 1);
    tbl[8]  = mk(0, 0, 1, 0, 0, 10'h0E5, 16'h0555, 1, 0, 2, 10'h0D4, 16'h0444, 2);
    tbl[9]  = mk(0, 1, 1, 0, 0, 10'h0F6, 16'h0666, 0, 1, 0, 10'h000, 16'h0444, 3);
    tbl[10] = mk(0, 0, 0, 0, 1, 10'h000, 16'h0000, 0, 1, 0, 10'h000, 16'h0444, 0);
    tbl[11] = mk(0, 0, 1, 0, 0, 10'h123, 16'h0777, 1, 1, 1, 10'h123, 16'h0777, 0);
    tbl[12] = mk(0, 0, 1, 0, 0, 10'h0AA, 16'h0888, 1, 0, 2, 10'h123, 16'h0777, 1);
    tbl[13] = mk(1, 0, 1, 1, 0, 10'h3FF, 16'h0BBB, 0, 1, 0, 10'h000, 16'h0000, 0);
    tbl[14] = mk(0, 0, 0, 1, 0, 10'h000, 16'h0000, 0, 1, 0, 10'h000, 16'h0000, 0);
    tbl[15] = mk(0, 0, 1, 0, 0, 10'h001, 16'h0999, 1, 1, 1, 10'h001, 16'h0999, 0);
    tbl[16] = mk(0, 0, 0, 0, 1, 10'h000, 16'h0000, 1, 1, 1, 10'h001, 16'h0999, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 10'h000, 16'h0000, 1, 1, 1, 10'h001, 16'h0999, 1);
    tbl[18] = mk(0, 1, 0, 1, 0, 10'h000, 16'h0000, 0, 1, 0, 10'h000, 16'h0999, 1);

    #2;
    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv;
      out_ready = tbl[i].ordy; stall_clr = tbl[i].sclr;
      in_ctrl = tbl[i].ctrl; in_data = DATA_W'(tbl[i].data);
      step();
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_ir);
      chk($sformatf("v%0d_occupancy", i), occupancy, tbl[i].e_occ);
      chk($sformatf("v%0d_out_ctrl", i), out_ctrl, tbl[i].e_ctrl);
      chk($sformatf("v%0d_out_data", i), out_data, DATA_W'(tbl[i].e_data));
      chk($sformatf("v%0d_stall_cnt", i), stall_cnt, tbl[i].e_stall);
    end
    rst = 0; flush = 0; stall_clr = 0;

    // Streaming: eight back-to-back entries with the consumer always ready.
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      sent[i]  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      in_valid = 1; in_ctrl = CTRL_W'(i + 16); in_data = sent[i];
      step();
      chk($sformatf("stream%0d_data", i), out_data, sent[i]);
      chk($sformatf("stream%0d_ctrl", i), out_ctrl, i + 16);
      chk($sformatf("stream%0d_occ", i), occupancy, 1);
    end
    in_valid = 0;
    step();
    chk("stream_drained", out_valid, 0);

    // Stall saturation: one held entry, consumer blocked for 20 cycles.
    in_valid = 1; in_ctrl = 10'h2AA; in_data = DATA_W'(16'hCAFE); out_ready = 0; stall_clr = 1;
    step();
    in_valid = 0; stall_clr = 0;
    for (int i = 0; i < 20; i++) step();
    chk("stall_saturated", stall_cnt, 15);
    stall_clr = 1;
    step();
    chk("stall_cleared", stall_cnt, 0);
    stall_clr = 0;

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      stall_clr = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_ctrl   = CTRL_W'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
